// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the INRT/A2D SPI bus arbiter.
package spi_arb_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, FIN} state_t;

  typedef enum logic {OWN_INRT = 1'b0, OWN_A2D = 1'b1} owner_t;

  // Command payload latched at grant and held for the whole transaction.
  typedef struct packed {
    owner_t            sel;
    logic [DATA_W-1:0] cmd;
  } spi_txn_t;

  localparam logic [DATA_W-1:0] TMO_ABORT_DATA = 16'hFFFF;

endpackage

// File: rtl/spi_arb_pick.sv
// Requester selection: INRT priority, optional anti-starvation for A2D.
// Starvation counter is built only when SPI_ARB_STARVE_EN is defined.
module spi_arb_pick
  import spi_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req_inrt,
  input  logic req_a2d,
  input  logic grant_en,
  output logic pick_a2d,
  output logic pick_vld
);

  logic starve_c;

`ifdef SPI_ARB_STARVE_EN
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_c = (starve_cnt_q == CNT_W'(STARVE_MAX));

  // Counts INRT wins while A2D is kept waiting; saturates because the tie then flips.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!req_a2d) begin
      starve_cnt_d = '0;
    end else if (grant_en) begin
      starve_cnt_d = pick_a2d ? '0 : starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic unused_cfg;

  assign starve_c   = 1'b0;
  assign unused_cfg = ^{clk, rst, grant_en, (STARVE_MAX == 0)};
`endif

  assign pick_vld = req_inrt | req_a2d;
  assign pick_a2d = req_a2d & (~req_inrt | starve_c);

endmodule

// File: rtl/spi_bus_arb.sv
// Shares one 16-bit SPI master between INRT and A2D, one whole transaction per grant,
// with timeout abort. Optional A2D anti-starvation via SPI_ARB_STARVE_EN.
module spi_bus_arb
  import spi_arb_pkg::*;
#(
  parameter int unsigned TMO_W      = 12,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_inrt,
  input  logic [DATA_W-1:0] cmd_inrt,
  output logic              done_inrt,
  input  logic              req_a2d,
  input  logic [DATA_W-1:0] cmd_a2d,
  output logic              done_a2d,
  output logic [DATA_W-1:0] rd_data,
  output logic              spi_wrt,
  output logic [DATA_W-1:0] spi_cmd,
  output logic              spi_sel,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rd,
  output logic              tmo_err
);

  localparam logic [TMO_W-1:0] TMO_LAST = '1;

  state_t            state_q, state_d;
  spi_txn_t          txn_q, txn_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              spi_wrt_q, spi_wrt_d;
  logic              done_inrt_q, done_inrt_d;
  logic              done_a2d_q, done_a2d_d;
  logic              tmo_err_q, tmo_err_d;
  logic              grant_en;
  logic              pick_a2d;
  logic              pick_vld;

  spi_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .req_inrt (req_inrt),
    .req_a2d  (req_a2d),
    .grant_en (grant_en),
    .pick_a2d (pick_a2d),
    .pick_vld (pick_vld)
  );

  // Next state and registered outputs; pulses are set on the edge entering GRANT/FIN.
  always_comb begin
    state_d     = state_q;
    txn_d       = txn_q;
    tmo_d       = tmo_q;
    rd_data_d   = rd_data_q;
    spi_wrt_d   = 1'b0;
    done_inrt_d = 1'b0;
    done_a2d_d  = 1'b0;
    tmo_err_d   = 1'b0;
    grant_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_en   = 1'b1;
          txn_d.sel  = pick_a2d ? OWN_A2D : OWN_INRT;
          txn_d.cmd  = pick_a2d ? cmd_a2d : cmd_inrt;
          spi_wrt_d  = 1'b1;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        // A completion in the same clock as the last count still counts as success.
        if (spi_done) begin
          rd_data_d   = spi_rd;
          done_inrt_d = (txn_q.sel == OWN_INRT);
          done_a2d_d  = (txn_q.sel == OWN_A2D);
          state_d     = FIN;
        end else if (tmo_d == TMO_LAST) begin
          rd_data_d   = TMO_ABORT_DATA;
          tmo_err_d   = 1'b1;
          done_inrt_d = (txn_q.sel == OWN_INRT);
          done_a2d_d  = (txn_q.sel == OWN_A2D);
          state_d     = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      txn_q       <= '0;
      tmo_q       <= '0;
      rd_data_q   <= '0;
      spi_wrt_q   <= 1'b0;
      done_inrt_q <= 1'b0;
      done_a2d_q  <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      txn_q       <= txn_d;
      tmo_q       <= tmo_d;
      rd_data_q   <= rd_data_d;
      spi_wrt_q   <= spi_wrt_d;
      done_inrt_q <= done_inrt_d;
      done_a2d_q  <= done_a2d_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign spi_cmd   = txn_q.cmd;
  assign spi_sel   = txn_q.sel;
  assign spi_wrt   = spi_wrt_q;
  assign rd_data   = rd_data_q;
  assign done_inrt = done_inrt_q;
  assign done_a2d  = done_a2d_q;
  assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_spi_bus_arb.sv
// Self-checking bench for spi_bus_arb: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model (honours SPI_ARB_STARVE_EN).
module tb_spi_bus_arb;

  localparam int unsigned STARVE_MAX = 3;
  localparam int unsigned TMO_LIMIT  = 4095;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_inrt, req_a2d;
  logic [15:0] cmd_inrt, cmd_a2d;
  logic        done_inrt, done_a2d;
  logic [15:0] rd_data;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_sel;
  logic        spi_done;
  logic [15:0] spi_rd;
  logic        tmo_err;

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] last_rd;
`ifdef SPI_ARB_STARVE_EN
  int starve = 0;
`endif

  spi_bus_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req_inrt  (req_inrt),
    .cmd_inrt  (cmd_inrt),
    .done_inrt (done_inrt),
    .req_a2d   (req_a2d),
    .cmd_a2d   (cmd_a2d),
    .done_a2d  (done_a2d),
    .rd_data   (rd_data),
    .spi_wrt   (spi_wrt),
    .spi_cmd   (spi_cmd),
    .spi_sel   (spi_sel),
    .spi_done  (spi_done),
    .spi_rd    (spi_rd),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Winner of a grant taken with the given request levels.
  function automatic bit model_pick(input bit ri, input bit ra);
    bit a2d;
`ifdef SPI_ARB_STARVE_EN
    a2d = ra && (!ri || starve == int'(STARVE_MAX));
    if (a2d || !ra) starve = 0;
    else            starve++;
`else
    a2d = ra && !ri;
`endif
    return a2d;
  endfunction

  function automatic void model_reset();
`ifdef SPI_ARB_STARVE_EN
    starve = 0;
`endif
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk($sformatf("%s_done_inrt", tag), 32'(done_inrt), 32'd0);
    chk($sformatf("%s_done_a2d", tag),  32'(done_a2d),  32'd0);
    chk($sformatf("%s_rd_data", tag),   32'(rd_data),   32'd0);
    chk($sformatf("%s_spi_wrt", tag),   32'(spi_wrt),   32'd0);
    chk($sformatf("%s_spi_cmd", tag),   32'(spi_cmd),   32'd0);
    chk($sformatf("%s_spi_sel", tag),   32'(spi_sel),   32'd0);
    chk($sformatf("%s_tmo_err", tag),   32'(tmo_err),   32'd0);
  endtask

  // One full transaction from IDLE; dly = WAIT clock carrying spi_done, 0 = never.
  task automatic txn(input string tag, input int dly, input logic [15:0] rd,
                     input bit drop_mid, output bit won_a2d);
    bit          a2d;
    logic [15:0] exp_cmd;
    logic [15:0] exp_rd;
    bit          exp_err;
    int          n;
    a2d     = model_pick(req_inrt, req_a2d);
    won_a2d = a2d;
    exp_cmd = a2d ? cmd_a2d : cmd_inrt;
    n = 0;
    while (spi_wrt !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk($sformatf("%s_grant_lat", tag), 32'(n), 32'd1);
    if (spi_wrt !== 1'b1) return;
    chk($sformatf("%s_sel", tag), 32'(spi_sel), 32'(a2d));
    chk($sformatf("%s_cmd", tag), 32'(spi_cmd), 32'(exp_cmd));
    tick();
    chk($sformatf("%s_wrt_pulse", tag), 32'(spi_wrt), 32'd0);
    if (drop_mid) begin
      if (a2d) req_a2d = 1'b0;
      else     req_inrt = 1'b0;
    end
    if (dly > 0) begin
      for (int k = 1; k < dly; k++) tick();
      spi_done = 1'b1;
      spi_rd   = rd;
      tick();
      spi_done = 1'b0;
      spi_rd   = 16'($urandom);
      exp_rd   = rd;
      exp_err  = 1'b0;
    end else begin
      for (int k = 1; k < int'(TMO_LIMIT); k++) tick();
      chk($sformatf("%s_no_early_done", tag), 32'(done_inrt | done_a2d), 32'd0);
      tick();
      exp_rd  = 16'hFFFF;
      exp_err = 1'b1;
    end
    chk($sformatf("%s_done_inrt", tag), 32'(done_inrt), 32'(!a2d));
    chk($sformatf("%s_done_a2d", tag),  32'(done_a2d),  32'(a2d));
    chk($sformatf("%s_tmo_err", tag),   32'(tmo_err),   32'(exp_err));
    chk($sformatf("%s_rd_data", tag),   32'(rd_data),   32'(exp_rd));
    chk($sformatf("%s_sel_hold", tag),  32'(spi_sel),   32'(a2d));
    chk($sformatf("%s_cmd_hold", tag),  32'(spi_cmd),   32'(exp_cmd));
    last_rd = exp_rd;
    if (a2d) req_a2d = 1'b0;
    else     req_inrt = 1'b0;
    tick();
    chk($sformatf("%s_done_pulse", tag), 32'(done_inrt | done_a2d | tmo_err), 32'd0);
  endtask

  initial begin
    bit won;
    int first_a2d;
    rst      = 1'b1;
    req_inrt = 1'b0;
    req_a2d  = 1'b0;
    cmd_inrt = '0;
    cmd_a2d  = '0;
    spi_done = 1'b0;
    spi_rd   = '0;
    last_rd  = '0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single INRT request.
    req_inrt = 1'b1;
    cmd_inrt = {8'hA2, 8'($urandom)};
    txn("single_inrt", int'($urandom_range(1, 8)), 16'h0055, 1'b0, won);

    // spi_done while idle must not disturb anything.
    spi_done = 1'b1;
    spi_rd   = 16'($urandom);
    tick();
    spi_done = 1'b0;
    tick();
    chk("stray_done_rd", 32'(rd_data), 32'(last_rd));
    chk("stray_done_pulse", 32'(done_inrt | done_a2d), 32'd0);

    // Tie: INRT first, then A2D.
    req_inrt = 1'b1; cmd_inrt = 16'($urandom);
    req_a2d  = 1'b1; cmd_a2d  = 16'($urandom);
    txn("tie_first", int'($urandom_range(1, 8)), 16'($urandom), 1'b0, won);
    chk("tie_first_owner", 32'(won), 32'd0);
    txn("tie_second", int'($urandom_range(1, 8)), 16'($urandom), 1'b0, won);
    chk("tie_second_owner", 32'(won), 32'd1);

    // Starvation: A2D held, INRT re-requests after every done.
    req_a2d   = 1'b1;
    cmd_a2d   = 16'($urandom);
    first_a2d = -1;
    for (int r = 0; r < 6; r++) begin
      req_inrt = 1'b1;
      cmd_inrt = 16'($urandom);
      txn($sformatf("starve%0d", r), int'($urandom_range(1, 4)), 16'($urandom), 1'b0, won);
      if (won && first_a2d < 0) first_a2d = r;
    end
`ifdef SPI_ARB_STARVE_EN
    chk("starve_first_a2d", 32'(first_a2d), 32'(STARVE_MAX));
`else
    chk("starve_first_a2d", 32'(first_a2d), 32'hFFFF_FFFF);
`endif
    if (req_a2d) txn("starve_drain", 2, 16'($urandom), 1'b0, won);

    // Timeout abort, then completion on the very last count.
    req_a2d = 1'b1;
    cmd_a2d = 16'($urandom);
    txn("timeout", 0, 16'h0000, 1'b0, won);
    req_inrt = 1'b1;
    cmd_inrt = 16'($urandom);
    txn("tmo_edge", int'(TMO_LIMIT), 16'($urandom), 1'b0, won);

    // Owner drops its request mid-transaction.
    req_inrt = 1'b1;
    cmd_inrt = 16'($urandom);
    txn("drop_mid", 5, 16'($urandom), 1'b1, won);

    // Reset while waiting on the SPI master.
    req_inrt = 1'b1;
    cmd_inrt = 16'($urandom);
    tick();
    tick();
    req_inrt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk_reset_outputs("rst_wait");
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rst_wait_quiet%0d", k), 32'(done_inrt | done_a2d | spi_wrt), 32'd0);
    end
    req_a2d = 1'b1;
    cmd_a2d = 16'($urandom);
    txn("post_rst", int'($urandom_range(1, 8)), 16'($urandom), 1'b0, won);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      if (!req_inrt && ($urandom % 2 == 0)) begin
        req_inrt = 1'b1;
        cmd_inrt = 16'($urandom);
      end
      if (!req_a2d && ($urandom % 2 == 0)) begin
        req_a2d = 1'b1;
        cmd_a2d = 16'($urandom);
      end
      if (!req_inrt && !req_a2d) begin
        req_inrt = 1'b1;
        cmd_inrt = 16'($urandom);
      end
      txn($sformatf("rand%0d", i), int'($urandom_range(1, 30)), 16'($urandom),
          ($urandom % 8 == 0), won);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
